// File: rtl/opal_pkg.sv
// opal_pkg: shared state encoding and default link geometry for the OPAL link
package opal_pkg;
    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, GAP} opal_tx_state_t;
    localparam int OPAL_CH = 24;
    localparam int OPAL_W  = 16;
endpackage

// File: rtl/opal_if.sv
// opal_if: parallel-word request side and serial link pins of the OPAL transmitter
interface opal_if #(
    parameter int CH = opal_pkg::OPAL_CH,
    parameter int W  = opal_pkg::OPAL_W
);
    logic            i_start;
    logic [CH*W-1:0] i_data;
    logic            o_sclk;
    logic            o_enable;
    logic [CH-1:0]   o_sdata;
    logic            o_busy;
    logic            o_done;
    modport master (input i_start, i_data, output o_sclk, o_enable, o_sdata, o_busy, o_done);
    modport slave (output i_start, i_data, input o_sclk, o_enable, o_sdata, o_busy, o_done);
endinterface

// File: rtl/opal_tick_gen.sv
// opal_tick_gen: half-period divider, tick on the last count, held at zero while cleared
module opal_tick_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    assign o_tick = cnt_q == CW'(CLK_DIV - 1);
    assign cnt_d  = (i_clear || o_tick) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/opal_tx.sv
// opal_tx: serializes one word per lane MSB first, with link strobe and bit clock
module opal_tx import opal_pkg::*; #(
    parameter int OPAL_CHANNEL_LENGTH = OPAL_CH,
    parameter int OPAL_INPUT_WIDTH    = OPAL_W,
    parameter int CLK_DIV             = 16,
    parameter int GAP_HALVES          = 4
) (
    input logic      clk,
    input logic      rst_n,
    opal_if.master   bus
);
    localparam int CH = OPAL_CHANNEL_LENGTH;
    localparam int W  = OPAL_INPUT_WIDTH;
    localparam int BW = $clog2(W) + 1;
    localparam int GW = $clog2(GAP_HALVES + 1);

    opal_tx_state_t         state_q, state_d;
    logic [CH-1:0][W-1:0]   sreg_q, sreg_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic                   sclk_q, sclk_d;
    logic                   en_q, en_d;
    logic [CH-1:0]          sdata_q, sdata_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tick;

    opal_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (state_q == IDLE),
        .o_tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sclk_d  = sclk_q;
        en_d    = en_q;
        sdata_d = sdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.i_start && !done_q) begin
                sreg_d  = bus.i_data;
                for (int c = 0; c < CH; c++) sdata_d[c] = bus.i_data[c*W + W - 1];
                bit_d   = '0;
                gap_d   = '0;
                sclk_d  = 1'b0;
                en_d    = 1'b1;
                busy_d  = 1'b1;
                state_d = LEAD;
            end
            LEAD: if (tick) begin
                sclk_d  = 1'b1;
                state_d = HIGH;
            end
            HIGH: if (tick) begin
                sclk_d  = 1'b0;
                state_d = LOW;
            end
            LOW: if (tick) begin
                bit_d = bit_q + 1'b1;
                if (bit_q == BW'(W - 1)) state_d = TRAIL;
                else begin
                    // the next bit appears together with the rising sclk edge
                    for (int c = 0; c < CH; c++) begin
                        sreg_d[c]  = {sreg_q[c][W-2:0], 1'b0};
                        sdata_d[c] = sreg_q[c][W-2];
                    end
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            TRAIL: if (tick) begin
                en_d    = 1'b0;
                sdata_d = '0;
                state_d = GAP;
            end
            GAP: if (tick) begin
                if (gap_q == GW'(GAP_HALVES - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else gap_d = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            sclk_q  <= 1'b0;
            en_q    <= 1'b0;
            sdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sclk_q  <= sclk_d;
            en_q    <= en_d;
            sdata_q <= sdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_sclk   = sclk_q;
    assign bus.o_enable = en_q;
    assign bus.o_sdata  = sdata_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;
endmodule

// File: tb/tb_opal_tx.sv
// tb_opal_tx: directed scenarios for opal_tx with a falling-edge model receiver
module tb_opal_tx;
    localparam int CH   = 24;
    localparam int W    = 16;
    localparam int DIV  = 4;
    localparam int GAPH = 4;
    localparam int BUSY = DIV * (2 + 2*W + GAPH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    opal_if #(.CH(CH), .W(W)) bus();

    opal_tx #(
        .OPAL_CHANNEL_LENGTH (CH),
        .OPAL_INPUT_WIDTH    (W),
        .CLK_DIV             (DIV),
        .GAP_HALVES          (GAPH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input logic [CH*W-1:0] d);
        bus.i_data  = d;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    // poke=1 re-requests with fresh data at busy cycles 10 and 100
    task automatic capture(input bit poke, output logic [CH-1:0][W-1:0] rx,
                           output int falls, output int busy_n, output int done_n);
        logic prev;
        rx = '0; falls = 0; busy_n = 0; done_n = 0;
        prev = bus.o_sclk;
        while (bus.o_busy && busy_n < 1000) begin
            busy_n++;
            if (prev && !bus.o_sclk && bus.o_enable) begin
                falls++;
                for (int c = 0; c < CH; c++) rx[c] = {rx[c][W-2:0], bus.o_sdata[c]};
            end
            prev = bus.o_sclk;
            if (bus.o_done) done_n++;
            if (poke && (busy_n == 10 || busy_n == 100)) begin
                bus.i_data  = ~bus.i_data;
                bus.i_start = 1'b1;
            end else bus.i_start = 1'b0;
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bus.o_done) done_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        bus.i_start = 1'b1;
        bus.i_data  = '1;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({bus.o_sclk, bus.o_enable, bus.o_busy, bus.o_done} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {bus.o_sclk, bus.o_enable, bus.o_busy, bus.o_done});
        end
        n_checks++;
        if (bus.o_sdata !== '0) begin
            n_fail++;
            $display("FAIL reset_sdata: got %h expected 0", bus.o_sdata);
        end
        bus.i_start = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({bus.o_busy, bus.o_enable} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_no_start: got busy/en %b expected 00", {bus.o_busy, bus.o_enable});
        end
    endtask

    task automatic test_single_frame;
        logic [CH-1:0][W-1:0] rx;
        int falls, busy_n, done_n;
        start_frame({CH{16'hA5C3}});
        capture(1'b0, rx, falls, busy_n, done_n);
        n_checks++;
        if (rx !== {CH{16'hA5C3}}) begin
            n_fail++;
            $display("FAIL single_data: got %h expected all lanes a5c3", rx);
        end
        n_checks++;
        if (falls !== 16) begin
            n_fail++;
            $display("FAIL single_falls: got %0d expected 16", falls);
        end
        n_checks++;
        if (busy_n !== BUSY) begin
            n_fail++;
            $display("FAIL single_busy: got %0d expected %0d", busy_n, BUSY);
        end
        n_checks++;
        if (done_n !== 1) begin
            n_fail++;
            $display("FAIL single_done: got %0d expected 1", done_n);
        end
        n_checks++;
        if ({bus.o_sclk, bus.o_enable, bus.o_sdata} !== '0) begin
            n_fail++;
            $display("FAIL single_idle_out: got %h expected 0", {bus.o_sclk, bus.o_enable, bus.o_sdata});
        end
    endtask

    task automatic test_per_lane;
        logic [CH-1:0][W-1:0] rx;
        logic [CH*W-1:0] d;
        int falls, busy_n, done_n;
        for (int c = 0; c < CH; c++) d[c*W +: W] = 16'(c * 16'h0101) ^ 16'h8001;
        start_frame(d);
        capture(1'b0, rx, falls, busy_n, done_n);
        for (int c = 0; c < CH; c++) begin
            n_checks++;
            if (rx[c] !== d[c*W +: W]) begin
                n_fail++;
                $display("FAIL lane_%0d: got %h expected %h", c, rx[c], d[c*W +: W]);
            end
        end
        n_checks++;
        if (falls !== 16) begin
            n_fail++;
            $display("FAIL lane_falls: got %0d expected 16", falls);
        end
    endtask

    task automatic test_start_while_busy;
        logic [CH-1:0][W-1:0] rx;
        logic [CH*W-1:0] d;
        int falls, busy_n, done_n;
        for (int c = 0; c < CH; c++) d[c*W +: W] = {8'(c), ~8'(c)};
        start_frame(d);
        capture(1'b1, rx, falls, busy_n, done_n);
        n_checks++;
        if (rx !== d) begin
            n_fail++;
            $display("FAIL busy_data: got %h expected %h", rx, d);
        end
        n_checks++;
        if (busy_n !== BUSY) begin
            n_fail++;
            $display("FAIL busy_len: got %0d expected %0d", busy_n, BUSY);
        end
        n_checks++;
        if (done_n !== 1) begin
            n_fail++;
            $display("FAIL busy_done: got %0d expected 1", done_n);
        end
        n_checks++;
        if (bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_not_queued: got busy %b expected 0", bus.o_busy);
        end
    endtask

    // the done cycle rejects the request, the following idle cycle accepts it
    task automatic test_back_to_back;
        int k, hi, lo;
        bus.i_data  = {CH{16'h1234}};
        bus.i_start = 1'b1;
        k = 0;
        while (!bus.o_enable && k < 400) begin @(negedge clk); k++; end
        hi = 0;
        while (bus.o_enable && hi < 400) begin @(negedge clk); hi++; end
        lo = 0;
        while (!bus.o_enable && lo < 400) begin @(negedge clk); lo++; end
        n_checks++;
        if (hi !== DIV * (2*W + 2)) begin
            n_fail++;
            $display("FAIL b2b_enable_high: got %0d expected %0d", hi, DIV * (2*W + 2));
        end
        n_checks++;
        if (lo !== GAPH * DIV + 2) begin
            n_fail++;
            $display("FAIL b2b_enable_low: got %0d expected %0d", lo, GAPH * DIV + 2);
        end
        bus.i_start = 1'b0;
        k = 0;
        while (bus.o_busy && k < 400) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_stop: got busy %b expected 0", bus.o_busy);
        end
    endtask

    task automatic test_mid_frame_reset;
        logic [CH-1:0][W-1:0] rx;
        logic [CH*W-1:0] d;
        logic prev;
        int falls, busy_n, done_n, k, f, dn;
        start_frame({CH{16'hF00D}});
        prev = bus.o_sclk; f = 0; k = 0;
        while (f < 7 && k < 1000) begin
            if (prev && !bus.o_sclk && bus.o_enable) f++;
            prev = bus.o_sclk;
            @(negedge clk); k++;
        end
        n_checks++;
        if (f !== 7) begin
            n_fail++;
            $display("FAIL mid_reach_bit7: got %0d expected 7", f);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_sclk, bus.o_enable, bus.o_busy, bus.o_done, bus.o_sdata} !== '0) begin
            n_fail++;
            $display("FAIL mid_async_clear: got %h expected 0",
                     {bus.o_sclk, bus.o_enable, bus.o_busy, bus.o_done, bus.o_sdata});
        end
        dn = 0;
        repeat (3) begin @(negedge clk); if (bus.o_done) dn++; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); if (bus.o_done) dn++; end
        n_checks++;
        if (dn !== 0) begin
            n_fail++;
            $display("FAIL mid_no_done: got %0d pulses expected 0", dn);
        end
        for (int c = 0; c < CH; c++) d[c*W +: W] = 16'h0F0F ^ 16'(c << 4);
        start_frame(d);
        capture(1'b0, rx, falls, busy_n, done_n);
        n_checks++;
        if (rx !== d) begin
            n_fail++;
            $display("FAIL mid_next_data: got %h expected %h", rx, d);
        end
        n_checks++;
        if (busy_n !== BUSY || falls !== 16 || done_n !== 1) begin
            n_fail++;
            $display("FAIL mid_next_frame: got busy %0d falls %0d done %0d expected %0d 16 1",
                     busy_n, falls, done_n, BUSY);
        end
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_data  = '0;
        @(negedge clk);
        test_reset;
        test_single_frame;
        test_per_lane;
        test_start_while_busy;
        test_back_to_back;
        test_mid_frame_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
